// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM stage: bus widths, MEM_* opcodes on the
// AluOpBus, the NOP register address, the MEM-stage FSM state encoding and
// small opcode-decode helpers used by mem_access and mem_load_ext.
// ---------------------------------------------------------------------------
package mem_access_pkg;

  typedef logic [7:0]  AluOpBus;
  typedef logic [31:0] RegBus;
  typedef logic [7:0]  MemBus;
  typedef logic [4:0]  RegAddr;

  localparam RegAddr NOPRegAddr = 5'd0;

  // Memory opcodes; any other AluOpBus value is a non-memory operation.
  localparam AluOpBus MEM_NOP = 8'h00;
  localparam AluOpBus MEM_LB  = 8'h20;
  localparam AluOpBus MEM_LH  = 8'h21;
  localparam AluOpBus MEM_LW  = 8'h22;
  localparam AluOpBus MEM_LBU = 8'h23;
  localparam AluOpBus MEM_LHU = 8'h24;
  localparam AluOpBus MEM_SB  = 8'h28;
  localparam AluOpBus MEM_SH  = 8'h29;
  localparam AluOpBus MEM_SW  = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } MemState;

  function automatic logic isLoadOp(input AluOpBus op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: isLoadOp = 1'b1;
      default:                                  isLoadOp = 1'b0;
    endcase
  endfunction

  function automatic logic isStoreOp(input AluOpBus op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: isStoreOp = 1'b1;
      default:                isStoreOp = 1'b0;
    endcase
  endfunction

  // Index of the final byte of the transfer (n-1 for n = 1/2/4).
  function automatic logic [1:0] lastByteIdx(input AluOpBus op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: lastByteIdx = 2'd1;
      MEM_LW, MEM_SW:          lastByteIdx = 2'd3;
      default:                 lastByteIdx = 2'd0;
    endcase
  endfunction

  function automatic logic isMisaligned(input AluOpBus op, input logic [1:0] addrLo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: isMisaligned = addrLo[0];
      MEM_LW, MEM_SW:          isMisaligned = |addrLo;
      default:                 isMisaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
// Combinational load-result formatter: picks the bytes a load actually
// fetched out of the 32-bit load buffer and sign- or zero-extends them.
// Bytes above the load width are masked so stale buffer contents from an
// earlier access never leak into the result.
// Ports:
//   i_aluop  - memory opcode of the load
//   i_buf    - load buffer, byte 0 = lowest address
//   o_result - extended 32-bit load result
// ---------------------------------------------------------------------------
module mem_load_ext
  import mem_access_pkg::*;
(
  input  AluOpBus     i_aluop,
  input  logic [31:0] i_buf,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = 32'd0;
    case (i_aluop)
      MEM_LB:  o_result = {{24{i_buf[7]}}, i_buf[7:0]};
      MEM_LBU: o_result = {24'd0, i_buf[7:0]};
      MEM_LH:  o_result = {{16{i_buf[15]}}, i_buf[15:0]};
      MEM_LHU: o_result = {16'd0, i_buf[15:0]};
      MEM_LW:  o_result = i_buf;
      default: o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// MEM pipeline stage driving a byte-wide memory port. Loads and stores of
// 1/2/4 bytes are split into sequential little-endian byte transfers while
// the stage stalls everything upstream; non-memory ops pass straight through.
// Optional build macro: MEM_MISALIGN_TRAP_EN - when defined, misaligned
// halfword/word accesses are refused in IDLE with a one-cycle misalign flag;
// when undefined misalign is tied low and misaligned accesses run bytewise.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   mem_wd/mem_wreg/mem_wdata     - destination/write-enable/data (store data)
//   mem_mem_addr, mem_aluop       - effective address and opcode
//   stall_req                     - stall EX/MEM and upstream
//   wb_wd/wb_wreg/wb_wdata        - toward the MEM/WB register
//   mc_req/mc_we/mc_addr/mc_dout  - byte memory request
//   mc_ack/mc_din                 - one-cycle acknowledge with read byte
//   misalign                      - misaligned-access flag
// ---------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_mem_addr,
  input  AluOpBus     mem_aluop,
  output logic        stall_req,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [7:0]  mc_dout,
  input  logic        mc_ack,
  input  logic [7:0]  mc_din,
  output logic        misalign
);

  MemState     r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_loadBuf;

  logic        w_isLoad;
  logic        w_isStore;
  logic        w_isMem;
  logic        w_misalign;
  logic [1:0]  w_lastIdx;
  logic [4:0]  w_byteShift;
  logic [31:0] w_loadResult;

  assign w_isLoad    = isLoadOp(mem_aluop);
  assign w_isStore   = isStoreOp(mem_aluop);
  assign w_isMem     = w_isLoad | w_isStore;
  assign w_lastIdx   = lastByteIdx(mem_aluop);
  assign w_byteShift = {r_cnt, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_isMem & isMisaligned(mem_aluop, mem_mem_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  mem_load_ext u_loadExt (
    .i_aluop  (mem_aluop),
    .i_buf    (r_loadBuf),
    .o_result (w_loadResult)
  );

  // State, byte counter and load buffer. The opcode and address are held
  // by the upstream stall for the whole access, so they are read live.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_loadBuf <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_isMem && !w_misalign) begin
            r_state <= ST_ACCESS;
            r_cnt   <= 2'd0;
          end
        end
        ST_ACCESS: begin
          if (mc_ack) begin
            if (w_isLoad) begin
              r_loadBuf[w_byteShift +: 8] <= mc_din;
            end
            if (r_cnt == w_lastIdx) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced to zero while reset is held. The IDLE pass-through
  // is combinational so non-memory ops see no extra latency.
  always_comb begin
    stall_req = 1'b0;
    wb_wd     = NOPRegAddr;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'd0;
    mc_req    = 1'b0;
    mc_we     = 1'b0;
    mc_addr   = 32'd0;
    mc_dout   = 8'd0;
    misalign  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_isMem) begin
            wb_wd    = mem_wd;
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end else if (w_misalign) begin
            misalign = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        ST_ACCESS: begin
          stall_req = 1'b1;
          mc_req    = 1'b1;
          mc_we     = w_isStore;
          mc_addr   = mem_mem_addr + {30'd0, r_cnt};
          mc_dout   = mem_wdata[w_byteShift +: 8];
        end
        ST_DONE: begin
          if (w_isLoad) begin
            wb_wd    = mem_wd;
            wb_wreg  = mem_wreg;
            wb_wdata = w_loadResult;
          end
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have inputs mem_wd (5), mem_wreg (1), mem_wdata (32), mem_mem_addr (32), mem_aluop (AluOpBus) from the EX/MEM register; for stores mem_wdata is store data.
REQ-004 SHALL have output stall_req, 1, request to stall EX/MEM and everything upstream.
REQ-005 SHALL have outputs wb_wd (5), wb_wreg (1), wb_wdata (32) toward the MEM/WB register.
REQ-006 SHALL have byte-wide memory port: outputs mc_req (1), mc_we (1), mc_addr (32), mc_dout (8); inputs mc_ack (1), mc_din (8).
REQ-007 SHALL have output misalign, 1, misaligned-access flag (see Configuration).

Function
REQ-008 SHALL decode mem_aluop: MEM_NOP/non-memory, LB, LH, LW, LBU, LHU, SB, SH, SW; byte count n = 1/2/4.
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE; registers: state, 2-bit byte counter cnt, 32-bit load buffer.
REQ-010 IDLE, non-memory op: wb_* = mem_wd/mem_wreg/mem_wdata combinationally, stall_req=0, mc_req=0; stay IDLE.
REQ-011 IDLE, memory op: stall_req=1, wb_* = bubble (0/0/0), mc_req=0; next state ACCESS, cnt=0.
REQ-012 ACCESS: stall_req=1, wb_* bubble, mc_req=1, mc_addr=mem_mem_addr+cnt (32-bit wrap), mc_we=1 for stores, mc_dout=byte cnt of mem_wdata (little-endian).
REQ-013 ACCESS: mc_addr/mc_we/mc_dout SHALL stay stable until mc_ack; mc_ack is a one-cycle pulse, mc_din valid in the same cycle.
REQ-014 ACCESS on mc_ack: loads write mc_din into buffer byte cnt; if cnt==n-1 next state DONE, else cnt+1.
REQ-015 DONE: stall_req=0, mc_req=0; loads drive wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata=buffer sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); stores drive bubble; next state IDLE unconditionally.
REQ-016 Latency with mc_ack every ACCESS cycle: n+2 cycles IDLE-to-result, stall_req high n+1 cycles.
REQ-017 mc_ack outside ACCESS SHALL be ignored.
REQ-018 Buffer bytes not loaded for current op SHALL not affect wb_wdata.

Reset
REQ-019 On rst: state=IDLE, cnt=0, buffer=0; next cycle mc_req=0, stall_req=0 unless a memory op is present (per REQ-011).
REQ-020 Reset mid-ACCESS SHALL abandon the access; no partial result reaches wb_*.
REQ-021 During rst all outputs SHALL be 0.

Configuration
REQ-022 Macro MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 in IDLE SHALL assert misalign=1 for one cycle, drive bubble, stall_req=0, no memory request, stay IDLE.
REQ-023 Macro undefined: misalign tied 0; misaligned accesses proceed byte-sequentially per REQ-012.

Structure
REQ-024 MEM_* opcodes, AluOpBus, RegBus, MemBus, NOPRegAddr and FSM state encodings SHALL live in the shared defines file.
REQ-025 Load extension SHALL be a combinational sub-module mem_load_ext (aluop, 32-bit buffer in, 32-bit result out).

Verification
REQ-026 LW addr 0x100, mc_din 0x78,0x56,0x34,0x12, ack each cycle -> mc_addr 0x100..0x103, DONE wb_wdata=0x12345678, stall_req high 5 cycles.
REQ-027 LB byte 0x80 -> wb_wdata=0xFFFFFF80; LBU same byte -> 0x00000080; LH 0x8001 -> 0xFFFF8001.
REQ-028 SH data 0x0000ABCD addr 0x202 (macro off) -> writes 0xCD@0x202 then 0xAB@0x203, mc_we=1, wb_wreg=0 in DONE.
REQ-029 LW with mc_ack delayed 3 cycles per byte -> mc_addr/mc_req held stable, result correct, stall_req high 13 cycles.
REQ-030 rst asserted after 2 LW bytes acked -> next cycle state IDLE, mc_req=0, wb_wreg=0; later stray mc_ack ignored.
REQ-031 Macro on, LW addr 0x101 -> misalign=1 one cycle, mc_req never asserted, stall_req=0, wb_wreg=0.
